id_regfile: RTL and testbench

Decode-stage register file: the receiving end of the write-back interface. Each cycle it accepts one register write from the write-back stage and serves two combinational operand reads to decode. A per-register pending-write scoreboard raises a stall when a source operand still has an outstanding write in flight.

---
 rtl/id_regfile_pkg.sv | 15 +
 rtl/id_scoreboard.sv | 65 ++++++
 rtl/id_regfile.sv | 88 ++++++++
 tb/tb_id_regfile.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_regfile_pkg.sv
// rtl/id_regfile_pkg.sv - shared widths and write-back bundle for the decode register file
package id_regfile_pkg;

  localparam int D_SIZE        = 32;
  localparam int ADDR_LINE_REG = 5;
  localparam int NUM_REGS      = 2 ** ADDR_LINE_REG;
  localparam int PEND_W        = 2;

  typedef struct packed {
    logic                     en;
    logic [ADDR_LINE_REG-1:0] addr;
    logic [D_SIZE-1:0]        data;
  } wb_t;

endpackage

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register pending-write counters, sticky overflow, per-source pending flags
module id_scoreboard
  import id_regfile_pkg::*;
#(
  parameter int ADDR_LINE_REG = id_regfile_pkg::ADDR_LINE_REG,
  parameter int PEND_W        = id_regfile_pkg::PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_inc_en,
  input  logic [ADDR_LINE_REG-1:0] i_inc_addr,
  input  logic                     i_dec_en,
  input  logic [ADDR_LINE_REG-1:0] i_dec_addr,
  input  logic [ADDR_LINE_REG-1:0] i_rs1_addr,
  input  logic [ADDR_LINE_REG-1:0] i_rs2_addr,
  output logic                     o_rs1_pend,
  output logic                     o_rs2_pend,
  output logic                     o_rs1_one,
  output logic                     o_rs2_one,
  output logic                     o_pend_ovf
);

  localparam int NREGS = 2 ** ADDR_LINE_REG;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] r_cnt [NREGS];
  logic              r_ovf;
  logic [NREGS-1:0]  w_inc_vec;
  logic [NREGS-1:0]  w_dec_vec;
  logic              w_ovf_hit;

  // register 0 is never tracked, so neither vector can select it
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    if (i_inc_en && i_inc_addr != '0) w_inc_vec[i_inc_addr] = 1'b1;
    if (i_dec_en && i_dec_addr != '0) w_dec_vec[i_dec_addr] = 1'b1;
  end

  assign w_ovf_hit = |(w_inc_vec & ~w_dec_vec) && (r_cnt[i_inc_addr] == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
          if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end
      end
      if (w_ovf_hit) r_ovf <= 1'b1;
    end
  end

  assign o_rs1_pend = (i_rs1_addr != '0) && (r_cnt[i_rs1_addr] != '0);
  assign o_rs2_pend = (i_rs2_addr != '0) && (r_cnt[i_rs2_addr] != '0);
  assign o_rs1_one  = (r_cnt[i_rs1_addr] == CNT_ONE);
  assign o_rs2_one  = (r_cnt[i_rs2_addr] == CNT_ONE);
  assign o_pend_ovf = r_ovf;

endmodule

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - decode register file with pending-write stall; REGFILE_BYPASS_EN enables write-back forwarding
module id_regfile
  import id_regfile_pkg::*;
#(
  parameter int D_SIZE        = id_regfile_pkg::D_SIZE,
  parameter int ADDR_LINE_REG = id_regfile_pkg::ADDR_LINE_REG,
  parameter int PEND_W        = id_regfile_pkg::PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_to_reg_f_wb_to_id,
  input  logic [ADDR_LINE_REG-1:0] reg_addr_f_wb_id,
  input  logic [D_SIZE-1:0]        reg_data_f_wb_id,
  input  logic [ADDR_LINE_REG-1:0] rs1_addr_id,
  input  logic [ADDR_LINE_REG-1:0] rs2_addr_id,
  output logic [D_SIZE-1:0]        rs1_data_id,
  output logic [D_SIZE-1:0]        rs2_data_id,
  input  logic                     issue_valid_id,
  input  logic                     issue_rd_we_id,
  input  logic [ADDR_LINE_REG-1:0] issue_rd_id,
  output logic                     stall_id,
  output logic                     pend_ovf
);

  localparam int NREGS = 2 ** ADDR_LINE_REG;

  logic [D_SIZE-1:0] r_regs [NREGS];
  wb_t               w_wb;
  logic              w_wr_en;
  logic              w_rs1_pend, w_rs2_pend;
  logic              w_rs1_one, w_rs2_one;
  logic              w_rs1_stall, w_rs2_stall;

  assign w_wb.en   = mem_to_reg_f_wb_to_id;
  assign w_wb.addr = reg_addr_f_wb_id;
  assign w_wb.data = reg_data_f_wb_id;
  assign w_wr_en   = w_wb.en && (w_wb.addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wb.addr] <= w_wb.data;
    end
  end

  id_scoreboard #(
    .ADDR_LINE_REG(ADDR_LINE_REG),
    .PEND_W       (PEND_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_inc_en  (issue_valid_id && issue_rd_we_id),
    .i_inc_addr(issue_rd_id),
    .i_dec_en  (w_wb.en),
    .i_dec_addr(w_wb.addr),
    .i_rs1_addr(rs1_addr_id),
    .i_rs2_addr(rs2_addr_id),
    .o_rs1_pend(w_rs1_pend),
    .o_rs2_pend(w_rs2_pend),
    .o_rs1_one (w_rs1_one),
    .o_rs2_one (w_rs2_one),
    .o_pend_ovf(pend_ovf)
  );

`ifdef REGFILE_BYPASS_EN
  logic w_rs1_hit, w_rs2_hit;

  assign w_rs1_hit   = w_wr_en && (w_wb.addr == rs1_addr_id);
  assign w_rs2_hit   = w_wr_en && (w_wb.addr == rs2_addr_id);
  assign rs1_data_id = w_rs1_hit ? w_wb.data : r_regs[rs1_addr_id];
  assign rs2_data_id = w_rs2_hit ? w_wb.data : r_regs[rs2_addr_id];
  // the last outstanding write is landing now, so the forwarded value is final
  assign w_rs1_stall = w_rs1_pend && !(w_rs1_hit && w_rs1_one);
  assign w_rs2_stall = w_rs2_pend && !(w_rs2_hit && w_rs2_one);
`else
  logic w_unused_one;

  assign w_unused_one = w_rs1_one ^ w_rs2_one;
  assign rs1_data_id  = r_regs[rs1_addr_id];
  assign rs2_data_id  = r_regs[rs2_addr_id];
  assign w_rs1_stall  = w_rs1_pend;
  assign w_rs2_stall  = w_rs2_pend;
`endif

  assign stall_id = w_rs1_stall || w_rs2_stall;

endmodule

// File: tb/tb_id_regfile.sv
// tb/tb_id_regfile.sv - self-checking bench for id_regfile against a behavioural model; honours REGFILE_BYPASS_EN
module tb_id_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        iss_v = 1'b0, iss_we = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        stall, ovf;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_ovf;

  id_regfile dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_to_reg_f_wb_to_id(wb_en),
    .reg_addr_f_wb_id     (wb_addr),
    .reg_data_f_wb_id     (wb_data),
    .rs1_addr_id          (rs1),
    .rs2_addr_id          (rs2),
    .rs1_data_id          (rs1_data),
    .rs2_data_id          (rs2_data),
    .issue_valid_id       (iss_v),
    .issue_rd_we_id       (iss_we),
    .issue_rd_id          (iss_rd),
    .stall_id             (stall),
    .pend_ovf             (ovf)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_ovf = 1'b0;
  endtask

  // Architectural effect of one clock edge on the model.
  task automatic model_step();
    bit inc, dec;
    inc = iss_v && iss_we && (iss_rd != 0);
    dec = wb_en && (wb_addr != 0);
    if (dec) m_regs[wb_addr] = wb_data;
    if (!(inc && dec && iss_rd == wb_addr)) begin
      if (inc) begin
        if (m_cnt[iss_rd] == 3) m_ovf = 1'b1;
        else m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
      end
      if (dec && m_cnt[wb_addr] > 0) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (BYP && wb_en && wb_addr == a && a != 0) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_src_stall(input logic [4:0] a);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    if (BYP && m_cnt[a] == 1 && wb_en && wb_addr == a) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    iss_v   = v;
    iss_we  = v;
    iss_rd  = rd;
    wb_en   = we;
    wb_addr = wa;
    wb_data = wd;
    rs1     = a1;
    rs2     = a2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0, 5, 7);
    #2;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL reset_rs1 got=%h exp=0", rs1_data); end
    total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL reset_rs2 got=%h exp=0", rs2_data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_write_read();
    drive(0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 0);
    #2;
    total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_r5 got=%h exp=deadbeef", rs1_data); end
  endtask

  task automatic test_r0();
    drive(1, 0, 1, 0, 32'h1234, 0, 0);
    #2;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL r0_same got=%h exp=0", rs1_data); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL r0_data got=%h exp=0", rs2_data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall); end
  endtask

  task automatic test_wb_same_cycle();
    drive(1, 3, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 3, 0);
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL r3_pend got=%b exp=1", stall); end
    drive(0, 0, 1, 3, 32'h55, 3, 0);
    #2;
    total++; if (stall !== !BYP) begin bad++; $display("FAIL r3_wb_stall got=%b exp=%b", stall, !BYP); end
    total++; if (rs1_data !== (BYP ? 32'h55 : 32'h0)) begin bad++; $display("FAIL r3_wb_data got=%h exp=%h", rs1_data, BYP ? 32'h55 : 32'h0); end
    tick();
    drive(0, 0, 0, 0, 0, 3, 0);
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r3_after_stall got=%b exp=0", stall); end
    total++; if (rs1_data !== 32'h55) begin bad++; $display("FAIL r3_after_data got=%h exp=55", rs1_data); end
  endtask

  task automatic test_double_pend();
    drive(1, 4, 0, 0, 0, 0, 0); tick();
    drive(1, 4, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 4, 32'hA1, 0, 4); tick();
    drive(0, 0, 0, 0, 0, 0, 4);
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL r4_one_left got=%b exp=1", stall); end
    drive(0, 0, 1, 4, 32'hA2, 0, 4); tick();
    drive(0, 0, 0, 0, 0, 0, 4);
    #2;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r4_cleared got=%b exp=0", stall); end
    total++; if (rs2_data !== 32'hA2) begin bad++; $display("FAIL r4_data got=%h exp=a2", rs2_data); end
  endtask

  task automatic test_saturate();
    drive(1, 9, 0, 0, 0, 0, 0); tick();
    drive(1, 9, 1, 9, 32'h99, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 9, 0);
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL r9_hold got=%b exp=1", stall); end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 9, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 9, 0);
    #2;
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 9, 32'h9, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 9, 0);
    #2;
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r9_drained got=%b exp=0", stall); end
    do_reset();
    #1;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_rst got=%b exp=0", ovf); end
  endtask

  task automatic test_random();
    logic [4:0]  rd, wa, a1, a2;
    logic [31:0] wd;
    logic        v, we;
    int          errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 1) == 0);
      rd = 5'($urandom_range(0, 11));
      wa = 5'($urandom_range(0, 11));
      a1 = 5'($urandom_range(0, 11));
      a2 = 5'($urandom_range(0, 11));
      wd = $urandom;
      drive(v, rd, we, wa, wd, a1, a2);
      #2;
      total++;
      if (rs1_data !== exp_data(a1) || rs2_data !== exp_data(a2) ||
          stall !== (exp_src_stall(a1) | exp_src_stall(a2)) || ovf !== m_ovf) begin
        bad++;
        if (errs < 10)
          $display("FAIL rand_%0d d1=%h/%h d2=%h/%h stall=%b/%b ovf=%b/%b", n,
                   rs1_data, exp_data(a1), rs2_data, exp_data(a2), stall,
                   exp_src_stall(a1) | exp_src_stall(a2), ovf, m_ovf);
        errs++;
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 1, 2, 32'h77, 0, 0); tick();
    drive(1, 2, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 2, 0);
    #2;
    total++; if (rs1_data !== 32'h77 || stall !== 1'b1) begin bad++; $display("FAIL r2_pre got=%h/%b exp=77/1", rs1_data, stall); end
    #1 rst = 1'b1;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL async_data got=%h exp=0", rs1_data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL async_stall got=%b exp=0", stall); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_r0();
    test_wb_same_cycle();
    test_double_pend();
    test_saturate();
    do_reset();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
